// File: rtl/mret_sequencer.sv
// rtl/mret_sequencer.sv - MRET return sequencer: reads mstatus/mepc, rewrites mstatus, redirects fetch
//
// Optional feature macro: MRET_PRIV_CHECK_EN
//   defined   : an MRET accepted below M-mode raises ILLEGAL_INSTRUCTION (cause 2,
//               tval = instruction bits) one cycle after acceptance, with no CSR traffic.
//   undefined : the sequence runs regardless of privilege; exc_* outputs are tied to 0.
//
// Ports:
//   clk_i, rst_i                      clock, synchronous active-high reset
//   mret_valid_i / mret_ready_o       MRET request handshake from issue
//   mret_insn_i, current_priv_i       instruction bits and current privilege level
//   kill_i                            pipeline flush; aborts an MRET that is not yet committed
//   csr_req_valid_o / csr_req_ready_i CSR request handshake (csr_cmd_o, csr_addr_o, csr_wdata_o)
//   csr_rsp_valid_i, csr_rdata_i      CSR response
//   redirect_valid_o, redirect_pc_o,
//   new_priv_o                        one-cycle fetch redirect to mepc at the restored privilege
//   exc_valid_o, exc_cause_o,
//   exc_tval_o                        one-cycle exception report (privilege check only)
//   busy_o                            high whenever a sequence is in flight
module mret_sequencer #(
    parameter int MXLEN = 64
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             mret_valid_i,
    output logic             mret_ready_o,
    input  logic [31:0]      mret_insn_i,
    input  logic [1:0]       current_priv_i,
    input  logic             kill_i,
    output logic             csr_req_valid_o,
    input  logic             csr_req_ready_i,
    output logic [3:0]       csr_cmd_o,
    output logic [11:0]      csr_addr_o,
    output logic [MXLEN-1:0] csr_wdata_o,
    input  logic             csr_rsp_valid_i,
    input  logic [MXLEN-1:0] csr_rdata_i,
    output logic             redirect_valid_o,
    output logic [MXLEN-1:0] redirect_pc_o,
    output logic [1:0]       new_priv_o,
    output logic             exc_valid_o,
    output logic [MXLEN-1:0] exc_cause_o,
    output logic [MXLEN-1:0] exc_tval_o,
    output logic             busy_o
);

    localparam logic [3:0]  CMD_READ_ONLY      = 4'b0101;
    localparam logic [3:0]  CMD_WRITE_AND_READ = 4'b0001;
    localparam logic [11:0] ADDR_MSTATUS       = 12'h300;
    localparam logic [11:0] ADDR_MEPC          = 12'h341;
    localparam logic [1:0]  PRIV_U             = 2'b00;
    localparam logic [1:0]  PRIV_RSVD          = 2'b10;
    localparam logic [1:0]  PRIV_M             = 2'b11;

    typedef enum logic [3:0] {
        S_IDLE,
        S_RD_STATUS,
        S_WT_STATUS,
        S_RD_EPC,
        S_WT_EPC,
        S_WR_STATUS,
        S_WT_WR,
        S_REDIRECT,
        S_EXC
    } state_t;

    state_t           state_q;
    logic             kill_pend_q;
    logic [MXLEN-1:0] mstatus_q;
    logic [MXLEN-1:0] mepc_q;

    logic             csr_req_valid_q;
    logic [3:0]       csr_cmd_q;
    logic [11:0]      csr_addr_q;
    logic [MXLEN-1:0] csr_wdata_q;
    logic             redirect_valid_q;
    logic [MXLEN-1:0] redirect_pc_q;
    logic [1:0]       new_priv_q;

    logic             accept;
    logic             req_hs;
    logic             priv_ok;
    logic [1:0]       old_mpp;
    logic [MXLEN-1:0] mstatus_wr_d;

    // Kill wins over a coincident request in IDLE.
    assign accept  = (state_q == S_IDLE) && mret_valid_i && !kill_i && !rst_i;
    assign req_hs  = csr_req_valid_q && csr_req_ready_i;
    assign old_mpp = mstatus_q[12:11];

    // mstatus after return: MIE <= MPIE, MPIE <= 1, MPP <= U, MPRV cleared when leaving to below M.
    always_comb begin
        mstatus_wr_d        = mstatus_q;
        mstatus_wr_d[3]     = mstatus_q[7];
        mstatus_wr_d[7]     = 1'b1;
        mstatus_wr_d[12:11] = PRIV_U;
        if (old_mpp != PRIV_M) begin
            mstatus_wr_d[17] = 1'b0;
        end
    end

`ifdef MRET_PRIV_CHECK_EN
    logic             exc_valid_q;
    logic [MXLEN-1:0] exc_cause_q;
    logic [MXLEN-1:0] exc_tval_q;

    assign priv_ok     = (current_priv_i == PRIV_M);
    assign exc_valid_o = exc_valid_q && !rst_i;
    assign exc_cause_o = rst_i ? '0 : exc_cause_q;
    assign exc_tval_o  = rst_i ? '0 : exc_tval_q;
`else
    logic unused_priv_inputs;

    assign priv_ok            = 1'b1;
    assign unused_priv_inputs = ^{current_priv_i, mret_insn_i};
    assign exc_valid_o        = 1'b0;
    assign exc_cause_o        = '0;
    assign exc_tval_o         = '0;
`endif

    // Outputs are registered, and additionally forced low during the reset cycle itself.
    assign mret_ready_o     = (state_q == S_IDLE) && !rst_i;
    assign busy_o           = (state_q != S_IDLE) && !rst_i;
    assign csr_req_valid_o  = csr_req_valid_q && !rst_i;
    assign csr_cmd_o        = rst_i ? '0 : csr_cmd_q;
    assign csr_addr_o       = rst_i ? '0 : csr_addr_q;
    assign csr_wdata_o      = rst_i ? '0 : csr_wdata_q;
    assign redirect_valid_o = redirect_valid_q && !rst_i;
    assign redirect_pc_o    = rst_i ? '0 : redirect_pc_q;
    assign new_priv_o       = rst_i ? '0 : new_priv_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q          <= S_IDLE;
            kill_pend_q      <= 1'b0;
            mstatus_q        <= '0;
            mepc_q           <= '0;
            csr_req_valid_q  <= 1'b0;
            csr_cmd_q        <= '0;
            csr_addr_q       <= '0;
            csr_wdata_q      <= '0;
            redirect_valid_q <= 1'b0;
            redirect_pc_q    <= '0;
            new_priv_q       <= '0;
`ifdef MRET_PRIV_CHECK_EN
            exc_valid_q      <= 1'b0;
            exc_cause_q      <= '0;
            exc_tval_q       <= '0;
`endif
        end else begin
            // Redirect and exception reports are single-cycle pulses.
            redirect_valid_q <= 1'b0;
            redirect_pc_q    <= '0;
            new_priv_q       <= '0;
`ifdef MRET_PRIV_CHECK_EN
            exc_valid_q      <= 1'b0;
            exc_cause_q      <= '0;
            exc_tval_q       <= '0;
`endif
            case (state_q)
                S_IDLE: begin
                    kill_pend_q <= 1'b0;
                    if (accept) begin
                        if (priv_ok) begin
                            state_q         <= S_RD_STATUS;
                            csr_req_valid_q <= 1'b1;
                            csr_cmd_q       <= CMD_READ_ONLY;
                            csr_addr_q      <= ADDR_MSTATUS;
                            csr_wdata_q     <= '0;
                        end else begin
                            state_q <= S_EXC;
`ifdef MRET_PRIV_CHECK_EN
                            exc_valid_q <= 1'b1;
                            exc_cause_q <= MXLEN'(2);
                            exc_tval_q  <= MXLEN'(mret_insn_i);
`endif
                        end
                    end
                end
                S_RD_STATUS, S_RD_EPC: begin
                    if (req_hs) begin
                        // A kill coinciding with the handshake cannot recall the read;
                        // remember it and drain the response first.
                        state_q         <= (state_q == S_RD_STATUS) ? S_WT_STATUS : S_WT_EPC;
                        kill_pend_q     <= kill_i;
                        csr_req_valid_q <= 1'b0;
                        csr_cmd_q       <= '0;
                        csr_addr_q      <= '0;
                    end else if (kill_i) begin
                        state_q         <= S_IDLE;
                        csr_req_valid_q <= 1'b0;
                        csr_cmd_q       <= '0;
                        csr_addr_q      <= '0;
                    end
                end
                S_WT_STATUS: begin
                    if (csr_rsp_valid_i) begin
                        mstatus_q <= csr_rdata_i;
                        if (kill_pend_q || kill_i) begin
                            state_q <= S_IDLE;
                        end else begin
                            state_q         <= S_RD_EPC;
                            csr_req_valid_q <= 1'b1;
                            csr_cmd_q       <= CMD_READ_ONLY;
                            csr_addr_q      <= ADDR_MEPC;
                            csr_wdata_q     <= '0;
                        end
                    end else if (kill_i) begin
                        kill_pend_q <= 1'b1;
                    end
                end
                S_WT_EPC: begin
                    if (csr_rsp_valid_i) begin
                        // mepc is held with bit 0 already cleared.
                        mepc_q <= {csr_rdata_i[MXLEN-1:1], 1'b0};
                        if (kill_pend_q || kill_i) begin
                            state_q <= S_IDLE;
                        end else begin
                            state_q         <= S_WR_STATUS;
                            csr_req_valid_q <= 1'b1;
                            csr_cmd_q       <= CMD_WRITE_AND_READ;
                            csr_addr_q      <= ADDR_MSTATUS;
                            csr_wdata_q     <= mstatus_wr_d;
                        end
                    end else if (kill_i) begin
                        kill_pend_q <= 1'b1;
                    end
                end
                S_WR_STATUS: begin
                    // The write handshake commits the MRET; kill is ignored from then on.
                    if (req_hs || kill_i) begin
                        state_q         <= req_hs ? S_WT_WR : S_IDLE;
                        csr_req_valid_q <= 1'b0;
                        csr_cmd_q       <= '0;
                        csr_addr_q      <= '0;
                        csr_wdata_q     <= '0;
                    end
                end
                S_WT_WR: begin
                    if (csr_rsp_valid_i) begin
                        state_q          <= S_REDIRECT;
                        redirect_valid_q <= 1'b1;
                        redirect_pc_q    <= mepc_q;
                        new_priv_q       <= (old_mpp == PRIV_RSVD) ? PRIV_U : old_mpp;
                    end
                end
                S_REDIRECT: state_q <= S_IDLE;
                S_EXC:      state_q <= S_IDLE;
                default:    state_q <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mret_sequencer.sv
// tb/tb_mret_sequencer.sv - self-checking bench for mret_sequencer
module tb_mret_sequencer;

    logic        clk = 1'b0;
    logic        rst_i = 1'b1;
    logic        mret_valid_i = 1'b0;
    logic        mret_ready_o;
    logic [31:0] mret_insn_i = 32'h30200073;
    logic [1:0]  current_priv_i = 2'b11;
    logic        kill_i = 1'b0;
    logic        csr_req_valid_o;
    logic        csr_req_ready_i = 1'b0;
    logic [3:0]  csr_cmd_o;
    logic [11:0] csr_addr_o;
    logic [63:0] csr_wdata_o;
    logic        csr_rsp_valid_i = 1'b0;
    logic [63:0] csr_rdata_i = '0;
    logic        redirect_valid_o;
    logic [63:0] redirect_pc_o;
    logic [1:0]  new_priv_o;
    logic        exc_valid_o;
    logic [63:0] exc_cause_o;
    logic [63:0] exc_tval_o;
    logic        busy_o;

    mret_sequencer #(.MXLEN(64)) dut (
        .clk_i(clk), .rst_i(rst_i),
        .mret_valid_i(mret_valid_i), .mret_ready_o(mret_ready_o),
        .mret_insn_i(mret_insn_i), .current_priv_i(current_priv_i), .kill_i(kill_i),
        .csr_req_valid_o(csr_req_valid_o), .csr_req_ready_i(csr_req_ready_i),
        .csr_cmd_o(csr_cmd_o), .csr_addr_o(csr_addr_o), .csr_wdata_o(csr_wdata_o),
        .csr_rsp_valid_i(csr_rsp_valid_i), .csr_rdata_i(csr_rdata_i),
        .redirect_valid_o(redirect_valid_o), .redirect_pc_o(redirect_pc_o), .new_priv_o(new_priv_o),
        .exc_valid_o(exc_valid_o), .exc_cause_o(exc_cause_o), .exc_tval_o(exc_tval_o),
        .busy_o(busy_o)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    // CSR slave knobs and observation logs
    logic [63:0] mstatus_val, mepc_val;
    int          stall_epc = 0, stall_other = 0, rsp_delay = 0;
    logic [11:0] log_addr[$];
    logic [3:0]  log_cmd[$];
    logic [63:0] log_wd[$];
    int          req_seen = 0, red_seen = 0, exc_seen = 0, stab_err = 0;
    logic [63:0] red_pc;
    bit          rsp_pending = 0;
    int          rsp_wait = 0;
    logic [63:0] rsp_data = '0;
    bit          in_req = 0;
    int          stall_left = 0;
    bit          prev_wait = 0;
    logic [11:0] p_addr;
    logic [3:0]  p_cmd;
    logic [63:0] p_wd;

    always @(posedge clk) begin
        cyc++;
        if (csr_req_valid_o && csr_req_ready_i) begin
            log_addr.push_back(csr_addr_o);
            log_cmd.push_back(csr_cmd_o);
            log_wd.push_back(csr_wdata_o);
            rsp_pending = 1;
            rsp_wait    = rsp_delay;
            if (csr_addr_o == 12'h341) rsp_data = mepc_val;
            else if (csr_cmd_o == 4'b0101) rsp_data = mstatus_val;
            else rsp_data = 64'hDEAD_BEEF_0BAD_F00D;
        end
        if (csr_req_valid_o) req_seen++;
        if (exc_valid_o) exc_seen++;
        if (redirect_valid_o) begin
            red_seen++;
            red_pc = redirect_pc_o;
        end
        if (prev_wait && (csr_req_valid_o !== 1'b1 || csr_addr_o !== p_addr ||
                          csr_cmd_o !== p_cmd || csr_wdata_o !== p_wd)) stab_err++;
        prev_wait = csr_req_valid_o && !csr_req_ready_i && !rst_i && !kill_i;
        p_addr = csr_addr_o;
        p_cmd  = csr_cmd_o;
        p_wd   = csr_wdata_o;
    end

    always @(negedge clk) begin
        if (csr_req_valid_o) begin
            if (!in_req) begin
                in_req     = 1;
                stall_left = (csr_addr_o == 12'h341) ? stall_epc : stall_other;
            end
            if (stall_left > 0) begin
                csr_req_ready_i = 1'b0;
                stall_left--;
            end else begin
                csr_req_ready_i = 1'b1;
            end
        end else begin
            in_req          = 0;
            csr_req_ready_i = 1'b0;
        end
        csr_rsp_valid_i = 1'b0;
        csr_rdata_i     = '0;
        if (rsp_pending) begin
            if (rsp_wait == 0) begin
                csr_rsp_valid_i = 1'b1;
                csr_rdata_i     = rsp_data;
                rsp_pending     = 0;
            end else begin
                rsp_wait--;
            end
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic any_out();
        return |{mret_ready_o, busy_o, csr_req_valid_o, csr_cmd_o, csr_addr_o, csr_wdata_o,
                 redirect_valid_o, redirect_pc_o, new_priv_o, exc_valid_o, exc_cause_o,
                 exc_tval_o};
    endfunction

    // Reference model of the architectural MRET effect.
    function automatic logic [63:0] m_wdata(input logic [63:0] s);
        logic [63:0] mpie, mpp, w;
        mpie = (s >> 7) & 64'h1;
        mpp  = (s >> 11) & 64'h3;
        w    = s & ~64'h1888;
        w    = w | (mpie << 3) | 64'h80;
        if (mpp != 64'h3) w = w & ~64'h20000;
        return w;
    endfunction

    function automatic logic [1:0] m_priv(input logic [63:0] s);
        logic [63:0] mpp;
        mpp = (s >> 11) & 64'h3;
        return (mpp == 64'h2) ? 2'b00 : mpp[1:0];
    endfunction

    task automatic clear_obs();
        log_addr.delete();
        log_cmd.delete();
        log_wd.delete();
        req_seen = 0;
        red_seen = 0;
        exc_seen = 0;
        stab_err = 0;
        red_pc   = '0;
    endtask

    task automatic start_mret(input logic [1:0] priv);
        int guard;
        clear_obs();
        @(negedge clk);
        mret_valid_i   = 1'b1;
        current_priv_i = priv;
        mret_insn_i    = 32'h30200073;
        guard = 0;
        while (!mret_ready_o && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        @(negedge clk);
        mret_valid_i = 1'b0;
    endtask

    task automatic run_mret(input logic [63:0] st, input logic [63:0] ep, input int se,
                            input int so, input int d, input logic [1:0] priv,
                            output int lat, output int nred, output logic [63:0] pc,
                            output logic [1:0] np, output int zero_err);
        int a;
        mstatus_val = st;
        mepc_val    = ep;
        stall_epc   = se;
        stall_other = so;
        rsp_delay   = d;
        start_mret(priv);
        a        = cyc;
        lat      = -1;
        nred     = 0;
        pc       = '0;
        np       = '0;
        zero_err = 0;
        for (int i = 0; i < 80; i++) begin
            if (redirect_valid_o) begin
                if (nred == 0) begin
                    lat = cyc - a + 1;
                    pc  = redirect_pc_o;
                    np  = new_priv_o;
                end
                nred++;
            end else if (redirect_pc_o != 0 || new_priv_o != 0) begin
                zero_err++;
            end
            if (!busy_o) break;
            @(negedge clk);
        end
    endtask

    typedef struct {
        logic [63:0] st;
        logic [63:0] ep;
        int          se;
        int          so;
        int          d;
        logic [63:0] wd;
        logic [63:0] pc;
        logic [1:0]  pr;
        int          lat;
    } vec_t;

    vec_t tbl[6];

    task automatic check_run(input string tag, input vec_t v, input logic [1:0] priv);
        int lat, nred, zero_err;
        logic [63:0] pc;
        logic [1:0] np;
        run_mret(v.st, v.ep, v.se, v.so, v.d, priv, lat, nred, pc, np, zero_err);
        chk({tag, " latency"}, 64'(lat), 64'(v.lat));
        chk({tag, " redirect_pc"}, pc, v.pc);
        chk({tag, " new_priv"}, 64'(np), 64'(v.pr));
        chk({tag, " redirect_count"}, 64'(nred), 64'd1);
        chk({tag, " txn_count"}, 64'(log_addr.size()), 64'd3);
        if (log_addr.size() == 3) begin
            chk({tag, " rd_status"}, {48'd0, log_addr[0], log_cmd[0]}, {48'd0, 12'h300, 4'b0101});
            chk({tag, " rd_epc"}, {48'd0, log_addr[1], log_cmd[1]}, {48'd0, 12'h341, 4'b0101});
            chk({tag, " wr_status"}, {48'd0, log_addr[2], log_cmd[2]}, {48'd0, 12'h300, 4'b0001});
            chk({tag, " wdata"}, log_wd[2], v.wd);
        end
        chk({tag, " req_stable"}, 64'(stab_err), 64'd0);
        chk({tag, " idle_zero"}, 64'(zero_err), 64'd0);
        chk({tag, " no_exc"}, 64'(exc_seen), 64'd0);
    endtask

    initial begin
        int guard;
        vec_t v;
        logic [1:0] rpriv;

        tbl[0] = '{64'h1880, 64'h80001234, 0, 0, 0, 64'h88, 64'h80001234, 2'b11, 7};
        tbl[1] = '{64'h20000, 64'h80001235, 0, 0, 0, 64'h80, 64'h80001234, 2'b00, 7};
        tbl[2] = '{64'h1880, 64'h80001234, 3, 0, 0, 64'h88, 64'h80001234, 2'b11, 10};
        tbl[3] = '{64'h21008, 64'h1001, 0, 1, 1, 64'h80, 64'h1000, 2'b00, 12};
        tbl[4] = '{64'hFFFF_0000_0002_0888, 64'h8000_0000_0000_0003, 2, 2, 0,
                   64'hFFFF_0000_0000_0088, 64'h8000_0000_0000_0002, 2'b01, 13};
        tbl[5] = '{64'h21800, 64'h4, 0, 0, 2, 64'h20080, 64'h4, 2'b11, 13};

        // Reset: every output low, request ignored.
        mret_valid_i = 1'b1;
        clear_obs();
        repeat (3) @(negedge clk);
        chk("reset_outputs", 64'(any_out()), 64'd0);
        chk("reset_no_csr", 64'(req_seen), 64'd0);
        rst_i        = 1'b0;
        mret_valid_i = 1'b0;
        @(negedge clk);
        chk("idle_ready", 64'(mret_ready_o), 64'd1);
        chk("idle_busy", 64'(busy_o), 64'd0);

        foreach (tbl[i]) check_run($sformatf("vec%0d", i), tbl[i], 2'b11);

        for (int i = 0; i < 20; i++) begin
            v.st  = {$urandom, $urandom};
            v.ep  = {$urandom, $urandom};
            v.se  = $urandom_range(0, 2);
            v.so  = $urandom_range(0, 2);
            v.d   = $urandom_range(0, 2);
            v.wd  = m_wdata(v.st);
            v.pc  = v.ep & ~64'h1;
            v.pr  = m_priv(v.st);
            v.lat = 7 + 2 * v.so + v.se + 3 * v.d;
`ifdef MRET_PRIV_CHECK_EN
            rpriv = 2'b11;
`else
            rpriv = 2'($urandom_range(0, 3));
`endif
            check_run($sformatf("rnd%0d", i), v, rpriv);
        end

        // Kill before the mstatus read handshake.
        stall_other = 3;
        stall_epc   = 0;
        rsp_delay   = 0;
        start_mret(2'b11);
        kill_i = 1'b1;
        @(negedge clk);
        kill_i = 1'b0;
        chk("kill_rd busy", 64'(busy_o), 64'd0);
        chk("kill_rd req_valid", 64'(csr_req_valid_o), 64'd0);
        repeat (4) @(negedge clk);
        chk("kill_rd txn", 64'(log_addr.size()), 64'd0);
        chk("kill_rd redirect", 64'(red_seen), 64'd0);

        // Kill coincident with a request in IDLE.
        clear_obs();
        @(negedge clk);
        mret_valid_i = 1'b1;
        kill_i       = 1'b1;
        @(negedge clk);
        mret_valid_i = 1'b0;
        kill_i       = 1'b0;
        chk("kill_idle busy", 64'(busy_o), 64'd0);
        repeat (3) @(negedge clk);
        chk("kill_idle req", 64'(req_seen), 64'd0);

        // Kill while waiting for mepc: drain the response, then idle, no write.
        mstatus_val = 64'h1880;
        mepc_val    = 64'h80001234;
        stall_other = 0;
        rsp_delay   = 2;
        start_mret(2'b11);
        guard = 0;
        while (log_addr.size() < 2 && guard < 30) begin
            @(negedge clk);
            guard++;
        end
        chk("kill_epc reached", 64'(log_addr.size()), 64'd2);
        kill_i = 1'b1;
        @(negedge clk);
        kill_i = 1'b0;
        chk("kill_epc drain_busy", 64'(busy_o), 64'd1);
        guard = 0;
        while (busy_o && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        chk("kill_epc idle", 64'(busy_o), 64'd0);
        chk("kill_epc rsp_consumed", 64'(rsp_pending), 64'd0);
        repeat (2) @(negedge clk);
        chk("kill_epc no_write", 64'(log_addr.size()), 64'd2);
        chk("kill_epc no_redirect", 64'(red_seen), 64'd0);
        check_run("after_kill", tbl[0], 2'b11);

        // Kill after commit is ignored.
        mstatus_val = 64'h20000;
        mepc_val    = 64'h80001235;
        rsp_delay   = 1;
        start_mret(2'b11);
        guard = 0;
        while (log_addr.size() < 3 && guard < 30) begin
            @(negedge clk);
            guard++;
        end
        kill_i = 1'b1;
        @(negedge clk);
        kill_i = 1'b0;
        guard = 0;
        while (busy_o && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        chk("kill_wr redirect", 64'(red_seen), 64'd1);
        chk("kill_wr pc", red_pc, 64'h80001234);

        // Reset while waiting for mstatus; the late response must be ignored.
        mstatus_val = 64'h1880;
        mepc_val    = 64'h80001234;
        rsp_delay   = 3;
        start_mret(2'b11);
        guard = 0;
        while (log_addr.size() < 1 && guard < 30) begin
            @(negedge clk);
            guard++;
        end
        rst_i = 1'b1;
        @(negedge clk);
        chk("rst_wt outputs", 64'(any_out()), 64'd0);
        rst_i = 1'b0;
        clear_obs();
        repeat (6) @(negedge clk);
        chk("rst_wt busy", 64'(busy_o), 64'd0);
        chk("rst_wt req", 64'(req_seen), 64'd0);
        chk("rst_wt redirect", 64'(red_seen), 64'd0);
        check_run("after_rst", tbl[0], 2'b11);

`ifdef MRET_PRIV_CHECK_EN
        clear_obs();
        start_mret(2'b01);
        chk("priv exc_valid", 64'(exc_valid_o), 64'd1);
        chk("priv exc_cause", exc_cause_o, 64'd2);
        chk("priv exc_tval", exc_tval_o, 64'h30200073);
        @(negedge clk);
        chk("priv exc_pulse", 64'(exc_valid_o), 64'd0);
        chk("priv exc_zero", exc_cause_o | exc_tval_o, 64'd0);
        chk("priv busy", 64'(busy_o), 64'd0);
        chk("priv no_csr", 64'(req_seen), 64'd0);
`else
        check_run("user_mret", tbl[1], 2'b01);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mret_sequencer.md
MRET_SEQUENCER -- requirements
Module: mret_sequencer

Interface
REQ-001 SHALL have parameter MXLEN, default 64, CSR data width.
REQ-002 SHALL have port clk_i  input  1  clock; all state updates on rising edge.
REQ-003 SHALL have port rst_i  input  1  reset, synchronous and active-high.
REQ-004 SHALL have ports mret_valid_i in 1, mret_ready_o out 1: MRET request handshake from the issue stage.
REQ-005 SHALL have ports mret_insn_i in 32 (instruction bits) and current_priv_i in 2 (privilege_level_t encoding).
REQ-006 SHALL have port kill_i  input  1  pipeline flush; aborts an MRET not yet committed.
REQ-007 SHALL have CSR request ports csr_req_valid_o out 1, csr_req_ready_i in 1, csr_cmd_o out 4 (csr_command_t), csr_addr_o out 12, csr_wdata_o out MXLEN.
REQ-008 SHALL have CSR response ports csr_rsp_valid_i in 1, csr_rdata_i in MXLEN.
REQ-009 SHALL have ports redirect_valid_o out 1, redirect_pc_o out MXLEN, new_priv_o out 2.
REQ-010 SHALL have ports exc_valid_o out 1, exc_cause_o out MXLEN, exc_tval_o out MXLEN, and busy_o out 1.

Function
REQ-011 SHALL implement states IDLE, RD_STATUS, WT_STATUS, RD_EPC, WT_EPC, WR_STATUS, WT_WR, REDIRECT.
REQ-012 SHALL drive mret_ready_o=1 only in IDLE with rst_i low; accept on mret_valid_i&&mret_ready_o, go to RD_STATUS.
REQ-013 SHALL, in RD_STATUS, assert csr_req_valid_o with cmd READ_ONLY (4'b0101), addr 0x300; hold all request fields stable until csr_req_ready_i; on handshake go WT_STATUS.
REQ-014 SHALL, in WT_STATUS, capture csr_rdata_i into a status register when csr_rsp_valid_i, go RD_EPC; responses arrive no earlier than the cycle after request handshake.
REQ-015 SHALL, in RD_EPC/WT_EPC, do the same with addr 0x341, capturing mepc.
REQ-016 SHALL, in WR_STATUS, issue WRITE_AND_READ (4'b0001) to 0x300 with wdata = captured mstatus with MIE(bit3)=old MPIE(bit7), MPIE=1, MPP(bits12:11)=2'b00, MPRV(bit17)=0 if old MPP!=2'b11, else unchanged; other bits unchanged.
REQ-017 SHALL, in WT_WR, wait for csr_rsp_valid_i (rdata ignored), then go REDIRECT.
REQ-018 SHALL, in REDIRECT, assert redirect_valid_o for exactly one cycle with redirect_pc_o = mepc with bit 0 cleared and new_priv_o = old MPP, except 2'b10 (RESERVED) maps to 2'b00; then IDLE.
REQ-019 SHALL give minimum latency (ready/response with no stalls) of redirect_valid_o 7 cycles after acceptance edge.
REQ-020 SHALL hold redirect_pc_o/new_priv_o/exc_* at 0 whenever the matching valid is low.
REQ-021 SHALL drive busy_o=1 in every state except IDLE.
REQ-022 SHALL, on kill_i in RD_STATUS or RD_EPC (before handshake) or WR_STATUS before handshake, return to IDLE next cycle with no further CSR request and no redirect.
REQ-023 SHALL, on kill_i in WT_STATUS or WT_EPC, set a kill-pending flag; consume the outstanding response, then go IDLE; the pending flag clears on entry to IDLE.
REQ-024 SHALL ignore kill_i from the WR_STATUS handshake onward (MRET committed).
REQ-025 SHALL ignore kill_i and mret_valid_i coincident in IDLE as a non-accept (kill wins).

Reset
REQ-026 SHALL, while rst_i high, force state IDLE, clear kill-pending, captured registers, and drive every output to 0 (including mret_ready_o).
REQ-027 SHALL abandon any in-flight sequence on reset without issuing further CSR traffic; responses arriving after reset in IDLE are ignored.

Configuration
REQ-028 SHALL, with macro MRET_PRIV_CHECK_EN defined, on acceptance with current_priv_i!=2'b11, skip CSR traffic and assert exc_valid_o one cycle after acceptance for one cycle with exc_cause_o=2 (ILLEGAL_INSTRUCTION, interrupt bit 0) and exc_tval_o=zero-extended mret_insn_i, then IDLE.
REQ-029 SHALL, without MRET_PRIV_CHECK_EN, execute the sequence regardless of current_priv_i and tie exc_valid_o, exc_cause_o, exc_tval_o to 0.

Verification
REQ-030 SHALL cover: mstatus=0x1880, mepc=0x80001234, no stalls -> write 0x0088, redirect_pc 0x80001234, new_priv 2'b11, redirect 7 cycles after accept.
REQ-031 SHALL cover: mstatus=0x20000, mepc=0x80001235 -> write 0x0080 (MPRV cleared), redirect_pc 0x80001234, new_priv 2'b00.
REQ-032 SHALL cover: csr_req_ready_i low 3 cycles in RD_EPC -> addr 0x341/cmd stable throughout, redirect at cycle 10.
REQ-033 SHALL cover: kill_i in WT_EPC, response 2 cycles later -> IDLE after response, no write to 0x300, no redirect; kill_i in WT_WR -> redirect still issued.
REQ-034 SHALL cover (MRET_PRIV_CHECK_EN): current_priv_i=2'b01, mret_insn_i=0x30200073 -> exc_valid_o one cycle, cause 2, tval 0x30200073, csr_req_valid_o never high.
REQ-035 SHALL cover: rst_i asserted in WT_STATUS -> all outputs 0 next cycle, IDLE, late response ignored, next MRET completes normally.
